// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encodings, default byte
// width and the occupancy-counter width helper.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer write port and uart_interface transmit handshake bundled together.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data_out;
  logic                  tx_busy;

  modport master (
    output wr_valid, wr_data, tx_busy,
    input  wr_ready, tx_start, tx_data_out
  );

  modport slave (
    input  wr_valid, wr_data, tx_busy,
    output wr_ready, tx_start, tx_data_out
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count and full/empty flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and feeds them one at a time into uart_interface,
// handshaking on tx_busy with a bounded wait for the transmitter to accept.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_feeder_if.slave               bus,
  output logic [count_width(DEPTH)-1:0] fifo_count,
  output logic                          overflow_err,
  output logic                          timeout_err,
  output logic                          idle
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  logic [1:0]            state_r;
  logic [TW-1:0]         timer_r;
  logic                  tx_start_r;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign push_s = bus.wr_valid && !full_s;
  assign pop_s  = (state_r == ST_IDLE) && !empty_s && !bus.tx_busy;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (bus.wr_data),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign bus.wr_ready    = !full_s;
  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data_out = tx_data_r;
  assign idle            = (state_r == ST_IDLE) && empty_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_err <= 1'b0;
    else     overflow_err <= bus.wr_valid && full_s;
  end

  // Launch handshake: tx_start is held until busy rises or the wait budget runs out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      timer_r     <= {TW{1'b0}};
      tx_start_r  <= 1'b0;
      tx_data_r   <= {DATA_WIDTH{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            tx_data_r  <= head_s;
            tx_start_r <= 1'b1;
            timer_r    <= {TW{1'b0}};
            state_r    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (bus.tx_busy) begin
            tx_start_r <= 1'b0;
            state_r    <= ST_WAIT_DONE;
          end else if (timer_r == TW'(START_TIMEOUT - 1)) begin
            tx_start_r  <= 1'b0;
            timeout_err <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) state_r <= ST_IDLE;
        end
        default: begin
          tx_start_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam int CW    = count_width(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] fifo_count;
  logic          overflow_err;
  logic          timeout_err;
  logic          idle;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_feeder_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_feeder #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          busy;
    logic          start;
    logic [7:0]    data;
    logic [CW-1:0] cnt;
    logic          idl;
    logic          rdy;
  } vec_t;

  vec_t vecs[15];

  // Reference model state: queue of accepted bytes plus a tx_busy responder.
  logic [7:0] q[$];
  bit         prev_start;
  bit         raised;
  bit         ignore_start;
  int         hi_cnt;
  int         rise_delay;
  int         hold_len;
  int         hold_left;
  int         peak;
  int         sent;

  task automatic sb_reset();
    q.delete();
    prev_start = 1'b0;
    raised     = 1'b0;
    ignore_start = 1'b0;
    hi_cnt     = 0;
    rise_delay = 1;
    hold_len   = 1;
    hold_left  = 0;
    peak       = 0;
    sent       = 0;
  endtask

  task automatic sb_step(input bit nv, input logic [7:0] nd, input bit rnd);
    bit acc, exp_ovf, launch, fell, exp_tmo;
    bus.wr_valid = nv;
    bus.wr_data  = nd;
    tick();
    exp_ovf = nv && (q.size() == DEPTH);
    acc     = nv && (q.size() < DEPTH);
    launch  = bus.tx_start && !prev_start;
    fell    = !bus.tx_start && prev_start;
    exp_tmo = fell && !raised;
    if (fell && !raised) check("sb_timeout_len", 64'(hi_cnt), 64'(TMO));
    if (launch) begin
      check("sb_launch_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        check("sb_tx_data", 64'(bus.tx_data_out), 64'(q[0]));
        void'(q.pop_front());
      end
      sent++;
      hi_cnt       = 0;
      raised       = 1'b0;
      rise_delay   = rnd ? int'($urandom_range(1, 4)) : 1;
      hold_len     = rnd ? int'($urandom_range(1, 6)) : 10;
      ignore_start = rnd && ($urandom_range(0, 9) == 0);
    end
    if (acc) q.push_back(nd);
    if (bus.tx_start) hi_cnt++;
    if (q.size() > peak) peak = q.size();
    check("sb_fifo_count", 64'(fifo_count), 64'(q.size()));
    check("sb_wr_ready", 64'(bus.wr_ready), 64'(q.size() != DEPTH));
    check("sb_overflow", 64'(overflow_err), 64'(exp_ovf));
    check("sb_timeout", 64'(timeout_err), 64'(exp_tmo));
    prev_start = bus.tx_start;
    if (bus.tx_busy) begin
      hold_left--;
      if (hold_left <= 0) bus.tx_busy = 1'b0;
    end else if (bus.tx_start && !ignore_start && hi_cnt >= rise_delay) begin
      bus.tx_busy = 1'b1;
      raised      = 1'b1;
      hold_left   = hold_len;
    end
  endtask

  task automatic sb_drain(input bit rnd, input string name);
    int guard = 0;
    while ((q.size() != 0 || !idle || bus.tx_busy) && guard < 3000) begin
      sb_step(1'b0, 8'h00, rnd);
      guard++;
    end
    check(name, 64'(guard < 3000), 64'd1);
  endtask

  initial begin
    string msg = "Hello, World!";
    int    k;
    int    hi;

    // Single byte 0x48, then a push coinciding with a pop.
    vecs[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h48, 5'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h48, 5'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h48, 5'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 5'd0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 5'd0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 5'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h48, 5'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h48, 5'd1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 5'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b1};

    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs",
          {bus.tx_start, bus.tx_data_out, fifo_count, idle, bus.wr_ready, overflow_err, timeout_err},
          {1'b0, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bus.wr_valid = vecs[i].v;
      bus.wr_data  = vecs[i].d;
      bus.tx_busy  = vecs[i].busy;
      tick();
      check($sformatf("vec%0d", i),
            {bus.tx_start, bus.tx_data_out, fifo_count, idle, bus.wr_ready, overflow_err, timeout_err},
            {vecs[i].start, vecs[i].data, vecs[i].cnt, vecs[i].idl, vecs[i].rdy, 2'b00});
    end

    // Timeout: transmitter never acknowledges.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    bus.tx_busy  = 1'b0;
    tick();
    bus.wr_valid = 1'b0;
    k = 0;
    while (!bus.tx_start && k < 10) begin
      tick();
      k++;
    end
    check("tmo_launch", 64'(bus.tx_start), 64'd1);
    check("tmo_data", 64'(bus.tx_data_out), 64'hA5);
    hi = 0;
    while (bus.tx_start && hi < 200) begin
      hi++;
      tick();
    end
    check("tmo_high_cycles", 64'(hi), 64'(TMO));
    check("tmo_pulse", 64'(timeout_err), 64'd1);
    check("tmo_count", 64'(fifo_count), 64'd0);
    check("tmo_idle", 64'(idle), 64'd1);
    tick();
    check("tmo_pulse_width", 64'(timeout_err), 64'd0);

    // Overflow: transmitter busy, 17 writes.
    bus.tx_busy = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(i);
      tick();
      check($sformatf("ovf_count%0d", i), 64'(fifo_count), 64'((i > DEPTH) ? DEPTH : i));
      check($sformatf("ovf_ready%0d", i), 64'(bus.wr_ready), 64'(i < DEPTH));
      check($sformatf("ovf_pulse%0d", i), 64'(overflow_err), 64'(i > DEPTH));
    end
    bus.wr_valid = 1'b0;
    tick();
    check("ovf_pulse_end", 64'(overflow_err), 64'd0);
    check("ovf_count_end", 64'(fifo_count), 64'(DEPTH));
    #2 rst = 1'b1;
    #1;
    check("ovf_reset", {fifo_count, idle, bus.wr_ready}, {5'd0, 1'b1, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while waiting for the transmitter to finish.
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(8'h30 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    tick();
    check("mid_launch", {bus.tx_start, bus.tx_data_out, fifo_count}, {1'b1, 8'h30, 5'd5});
    bus.tx_busy = 1'b1;
    tick();
    check("mid_wait", {bus.tx_start, fifo_count, idle}, {1'b0, 5'd5, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("mid_reset", {bus.tx_start, bus.tx_data_out, fifo_count, idle, bus.wr_ready},
          {1'b0, 8'h00, 5'd0, 1'b1, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    bus.tx_busy = 1'b0;

    // "Hello, World!" back-to-back through a slow transmitter.
    sb_reset();
    for (int i = 0; i < msg.len(); i++) sb_step(1'b1, msg[i], 1'b0);
    sb_drain(1'b0, "hello_drain");
    check("hello_sent", 64'(sent), 64'd13);
    check("hello_peak", 64'(peak == 12 || peak == 13), 64'd1);

    // Randomized traffic.
    sb_reset();
    for (int i = 0; i < 3000; i++) sb_step($urandom_range(0, 2) != 0, 8'($urandom), 1'b1);
    sb_drain(1'b1, "rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
